// File: rtl/keccak_pad_stream_pkg.sv
// Shared constants for the Keccak/SHA-3 streaming pad stage: rates, pad bytes,
// FSM encoding and descriptor field layout.
package keccak_pad_stream_pkg;

    localparam int RATE256_LANES_DEF = 17;
    localparam int RATE512_LANES_DEF = 9;

    localparam logic [7:0] PAD_FIRST = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    localparam int PARMS_LEN_LSB = 0;
    localparam int PARMS_DIG_LSB = 32;
    localparam int PARMS_FIELD_W = 32;

    localparam logic [31:0] DIGEST_512 = 32'd512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_PAD    = 2'd2
    } state_t;

    // Keeps the r valid message bytes of a short final word and starts padding at byte r.
    function automatic logic [63:0] pad_tail(input logic [63:0] word, input logic [2:0] r);
        logic [63:0] res;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(r))
                res[8*k +: 8] = word[8*k +: 8];
            else if (k == int'(r))
                res[8*k +: 8] = PAD_FIRST;
        end
        return res;
    endfunction

endpackage

// File: rtl/keccak_pad_stream.sv
// Streams a byte-length message into rate-sized lane blocks with SHA-3 padding
// (0x06 ... 0x80), one FSM driving a single registered lane output.
module keccak_pad_stream
    import keccak_pad_stream_pkg::*;
#(
    parameter int RATE256_LANES = RATE256_LANES_DEF,
    parameter int RATE512_LANES = RATE512_LANES_DEF
) (
    input  logic        Clk40,
    input  logic        reset_n,
    input  logic        parms_valid,
    input  logic [63:0] parms_element,
    output logic        parms_ready,
    input  logic        data_valid,
    input  logic [63:0] data_element,
    output logic        data_ready,
    output logic        lane_valid,
    output logic [63:0] lane_data,
    output logic        lane_block_end,
    output logic        lane_msg_end,
    input  logic        lane_ready
);

    state_t      state;
    logic [31:0] len_left;
    logic [7:0]  rate_last;
    logic [7:0]  lane_idx;
    logic        pad06_pending;

    logic        out_free;
    logic        parms_fire;
    logic        data_fire;
    logic        is_last_lane;
    logic        final_word;
    logic [2:0]  tail_bytes;
    logic        tail_short;
    logic [63:0] absorb_word;
    logic [63:0] pad_word;

    assign out_free     = !lane_valid || lane_ready;
    assign data_ready   = (state == ST_ABSORB) && out_free;
    assign parms_fire   = parms_valid && parms_ready;
    assign data_fire    = data_valid && data_ready;
    assign is_last_lane = (lane_idx == rate_last);
    assign final_word   = (len_left <= 32'd8);
    assign tail_bytes   = len_left[2:0];
    assign tail_short   = final_word && (tail_bytes != 3'd0);

    // A short final word carries the 0x06 marker; on the last lane it also takes 0x80.
    always_comb begin
        absorb_word = data_element;
        if (tail_short) begin
            absorb_word = pad_tail(data_element, tail_bytes);
            if (is_last_lane)
                absorb_word[63:56] = absorb_word[63:56] ^ PAD_LAST;
        end
    end

    always_comb begin
        pad_word = '0;
        if (pad06_pending)
            pad_word[7:0] = PAD_FIRST;
        if (is_last_lane)
            pad_word[63:56] = pad_word[63:56] ^ PAD_LAST;
    end

    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            len_left       <= '0;
            rate_last      <= '0;
            lane_idx       <= '0;
            pad06_pending  <= 1'b0;
            parms_ready    <= 1'b0;
            lane_valid     <= 1'b0;
            lane_data      <= '0;
            lane_block_end <= 1'b0;
            lane_msg_end   <= 1'b0;
        end else begin
            if (lane_valid && lane_ready)
                lane_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (parms_fire) begin
                        parms_ready   <= 1'b0;
                        len_left      <= parms_element[PARMS_LEN_LSB +: PARMS_FIELD_W];
                        lane_idx      <= '0;
                        rate_last     <= (parms_element[PARMS_DIG_LSB +: PARMS_FIELD_W] == DIGEST_512)
                                         ? 8'(RATE512_LANES - 1) : 8'(RATE256_LANES - 1);
                        pad06_pending <= (parms_element[PARMS_LEN_LSB +: PARMS_FIELD_W] == 32'd0);
                        state         <= (parms_element[PARMS_LEN_LSB +: PARMS_FIELD_W] != 32'd0)
                                         ? ST_ABSORB : ST_PAD;
                    end else begin
                        parms_ready <= 1'b1;
                    end
                end

                ST_ABSORB: begin
                    if (data_fire) begin
                        lane_valid     <= 1'b1;
                        lane_data      <= absorb_word;
                        lane_block_end <= is_last_lane;
                        lane_msg_end   <= is_last_lane && tail_short;
                        lane_idx       <= is_last_lane ? 8'd0 : lane_idx + 8'd1;
                        len_left       <= final_word ? 32'd0 : len_left - 32'd8;
                        if (final_word) begin
                            state         <= ST_PAD;
                            pad06_pending <= !tail_short;
                        end
                    end
                end

                ST_PAD: begin
                    // Once the message-end lane is loaded, only its handshake matters.
                    if (lane_valid && lane_msg_end) begin
                        if (lane_ready) begin
                            state       <= ST_IDLE;
                            parms_ready <= 1'b1;
                            lane_idx    <= '0;
                        end
                    end else if (out_free) begin
                        lane_valid     <= 1'b1;
                        lane_data      <= pad_word;
                        lane_block_end <= is_last_lane;
                        lane_msg_end   <= is_last_lane;
                        lane_idx       <= is_last_lane ? 8'd0 : lane_idx + 8'd1;
                        pad06_pending  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_pad_stream.sv
// Scoreboard bench for keccak_pad_stream: a byte-level SHA-3 padding model fills
// the expected-lane queue, and a negedge monitor pops and compares each handshake.
module tb_keccak_pad_stream;

    logic        Clk40 = 1'b0;
    logic        reset_n = 1'b0;
    logic        parms_valid = 1'b0;
    logic [63:0] parms_element = '0;
    logic        parms_ready;
    logic        data_valid = 1'b0;
    logic [63:0] data_element = '0;
    logic        data_ready;
    logic        lane_valid;
    logic [63:0] lane_data;
    logic        lane_block_end;
    logic        lane_msg_end;
    logic        lane_ready = 1'b0;

    typedef struct {
        logic [63:0] data;
        logic        be;
        logic        me;
    } lane_t;

    lane_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  msg_bytes [0:511];
    bit          hold_low = 1'b0;

    bit          stall_prev = 1'b0;
    bit          parms_chk = 1'b0;
    logic [63:0] prev_data;
    logic        prev_be;
    logic        prev_me;

    keccak_pad_stream dut (
        .Clk40          (Clk40),
        .reset_n        (reset_n),
        .parms_valid    (parms_valid),
        .parms_element  (parms_element),
        .parms_ready    (parms_ready),
        .data_valid     (data_valid),
        .data_element   (data_element),
        .data_ready     (data_ready),
        .lane_valid     (lane_valid),
        .lane_data      (lane_data),
        .lane_block_end (lane_block_end),
        .lane_msg_end   (lane_msg_end),
        .lane_ready     (lane_ready)
    );

    initial forever #5 Clk40 = ~Clk40;

    initial forever begin
        @(posedge Clk40);
        #1;
        lane_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: pad the byte string to a whole number of rate blocks, then cut into lanes.
    task automatic buildExpected(input int len, input int digest);
        int lanes;
        int rb;
        int total;
        lanes = (digest == 512) ? 9 : 17;
        rb    = lanes * 8;
        total = (len / rb + 1) * rb;
        for (int w = 0; w < total / 8; w++) begin
            lane_t e;
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                int i;
                logic [7:0] b;
                i = w * 8 + k;
                b = (i < len) ? msg_bytes[i] : 8'h00;
                if (i == len)
                    b = b ^ 8'h06;
                if (i == total - 1)
                    b = b ^ 8'h80;
                e.data[8*k +: 8] = b;
            end
            e.be = ((w + 1) % lanes == 0);
            e.me = (w == total / 8 - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fillRandom(input int len);
        for (int i = 0; i < len; i++)
            msg_bytes[i] = 8'($urandom);
    endtask

    task automatic applyStimulus(input int len, input int digest, input int abort_after);
        int nwords;
        int cyc;
        bit fired;
        nwords = (len + 7) / 8;
        buildExpected(len, digest);

        data_valid   = 1'b1;
        data_element = {$urandom, $urandom};
        @(negedge Clk40);
        checkOutput("data_ready_idle", {63'd0, data_ready}, 64'd0);
        @(posedge Clk40);
        #1;
        data_valid = 1'b0;

        parms_element = {digest[31:0], len[31:0]};
        parms_valid   = 1'b1;
        cyc = 0;
        do begin
            @(negedge Clk40);
            fired = parms_ready;
            cyc++;
            @(posedge Clk40);
            #1;
        end while (!fired && cyc < 500);
        parms_valid = 1'b0;
        if (!fired) begin
            checks++;
            errors++;
            $display("[TB] FAIL parms_timeout: got no parms_ready, expected handshake");
            return;
        end

        for (int w = 0; w < nwords; w++) begin
            if (abort_after >= 0 && w >= abort_after)
                return;
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clk40);
                #1;
            end
            for (int k = 0; k < 8; k++)
                data_element[8*k +: 8] = (w * 8 + k < len) ? msg_bytes[w * 8 + k] : 8'($urandom);
            data_valid = 1'b1;
            cyc = 0;
            do begin
                @(negedge Clk40);
                fired = data_ready;
                cyc++;
                @(posedge Clk40);
                #1;
            end while (!fired && cyc < 500);
            data_valid = 1'b0;
            if (!fired) begin
                checks++;
                errors++;
                $display("[TB] FAIL data_timeout: got no data_ready, expected handshake on word %0d", w);
                return;
            end
        end
    endtask

    task automatic waitDrain(input string name);
        int cyc;
        cyc = 0;
        @(posedge Clk40);
        #1;
        while ((exp_q.size() != 0 || !parms_ready) && cyc < 4000) begin
            @(posedge Clk40);
            #1;
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0 || !parms_ready) begin
            errors++;
            $display("[TB] FAIL drain_%s: got %0d lanes outstanding and parms_ready=%0b, expected 0 and 1",
                     name, exp_q.size(), parms_ready);
            exp_q.delete();
        end
    endtask

    // Monitor: handshakes, stall stability and the post-message parms_ready rise.
    always @(negedge Clk40) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
            parms_chk  = 1'b0;
        end else begin
            if (parms_chk) begin
                checkOutput("parms_ready_after_msg_end", {63'd0, parms_ready}, 64'd1);
                parms_chk = 1'b0;
            end
            if (stall_prev) begin
                checkOutput("stall_valid", {63'd0, lane_valid}, 64'd1);
                checkOutput("stall_data", lane_data, prev_data);
                checkOutput("stall_flags", {62'd0, lane_block_end, lane_msg_end}, {62'd0, prev_be, prev_me});
            end
            if (lane_valid && !lane_ready) begin
                checkOutput("stall_data_ready", {63'd0, data_ready}, 64'd0);
                stall_prev = 1'b1;
                prev_data  = lane_data;
                prev_be    = lane_block_end;
                prev_me    = lane_msg_end;
            end else begin
                stall_prev = 1'b0;
            end
            if (lane_valid && lane_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_lane: got %h, expected no lane", lane_data);
                end else begin
                    lane_t e;
                    e = exp_q.pop_front();
                    checkOutput("lane_data", lane_data, e.data);
                    checkOutput("lane_flags", {62'd0, lane_block_end, lane_msg_end}, {62'd0, e.be, e.me});
                end
                if (lane_msg_end)
                    parms_chk = 1'b1;
            end
        end
    end

    initial begin
        logic [63:0] w0;
        logic [63:0] w1;
        int len;
        int digest;

        #12;
        checkOutput("reset_lane_valid", {63'd0, lane_valid}, 64'd0);
        checkOutput("reset_parms_ready", {63'd0, parms_ready}, 64'd0);
        checkOutput("reset_data_ready", {63'd0, data_ready}, 64'd0);
        checkOutput("reset_lane_data", lane_data, 64'd0);
        @(posedge Clk40);
        #3;
        reset_n = 1'b1;
        @(posedge Clk40);
        #1;
        checkOutput("parms_ready_after_reset", {63'd0, parms_ready}, 64'd1);

        applyStimulus(0, 256, -1);
        waitDrain("len0");

        w0 = 64'h6168747345207341;
        w1 = 64'h6465727269747320;
        for (int k = 0; k < 8; k++) begin
            msg_bytes[k]     = w0[8*k +: 8];
            msg_bytes[8 + k] = w1[8*k +: 8];
        end
        applyStimulus(16, 256, -1);
        waitDrain("len16");

        fillRandom(13);  applyStimulus(13, 512, -1);  waitDrain("len13");
        fillRandom(71);  applyStimulus(71, 512, -1);  waitDrain("len71");
        fillRandom(72);  applyStimulus(72, 512, -1);  waitDrain("len72");
        fillRandom(136); applyStimulus(136, 256, -1); waitDrain("len136");
        fillRandom(135); applyStimulus(135, 256, -1); waitDrain("len135");
        fillRandom(128); applyStimulus(128, 256, -1); waitDrain("len128");
        fillRandom(7);   applyStimulus(7, 512, -1);   waitDrain("len7");
        fillRandom(20);  applyStimulus(20, 384, -1);  waitDrain("dig384");

        fillRandom(64);
        fork
            applyStimulus(64, 512, -1);
            begin
                repeat (4) @(posedge Clk40);
                #2;
                hold_low = 1'b1;
                repeat (5) @(posedge Clk40);
                #2;
                hold_low = 1'b0;
            end
        join
        waitDrain("stall");

        fillRandom(40);
        applyStimulus(40, 256, 3);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_lane_valid", {63'd0, lane_valid}, 64'd0);
        checkOutput("midreset_flags", {62'd0, lane_block_end, lane_msg_end}, 64'd0);
        checkOutput("midreset_parms_ready", {63'd0, parms_ready}, 64'd0);
        checkOutput("midreset_data_ready", {63'd0, data_ready}, 64'd0);
        exp_q.delete();
        @(posedge Clk40);
        #3;
        reset_n = 1'b1;
        @(posedge Clk40);
        #1;
        checkOutput("midreset_parms_ready_rise", {63'd0, parms_ready}, 64'd1);
        checkOutput("midreset_no_lane", {63'd0, lane_valid}, 64'd0);

        for (int j = 0; j < 20; j++) begin
            len    = $urandom_range(0, 200);
            digest = ($urandom_range(0, 1) == 0) ? 256 : 512;
            fillRandom(len);
            applyStimulus(len, digest, -1);
            waitDrain("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
